tbt_accumulator: RTL and testbench
==================================

Name: tbt_accumulator

Overview:
- Per-channel turn-by-turn (TbT) integrator in the ADC clock domain of the DSBPM datapath.
- Consumes mixed I/Q products from the LO mixer and sums them over one machine turn.
- Emits one I/Q sum pair per turn to the downstream CIC decimators (FA/SA chains).
- A flywheel keeps turn boundaries aligned to the EVR-derived turn marker; the marker may be sparse.

Parameters:
- PRODUCT_WIDTH, 33, signed width of each mixer product (AXI_ADC_SAMPLE_WIDTH + LO_WIDTH - 1).
- SITE_SAMPLES_PER_TURN, 100, maximum samples per turn; sets counter width.
- CNT_WIDTH, $clog2(SITE_SAMPLES_PER_TURN+1), sample-counter width.
- ACC_WIDTH, PRODUCT_WIDTH + CNT_WIDTH, signed accumulator/output width.
- TURN_CNT_WIDTH, 32, turn counter width.

Ports:
- adcClk  in  1  ADC-domain clock; all logic on rising edge.
- adcResetN  in  1  synchronous, active-low reset.
- samplesPerTurn  in  CNT_WIDTH  configured samples per turn; quasi-static.
- turnMarker  in  1  one-cycle pulse, coincident with the first sample of a turn.
- sampleValid  in  1  productI/productQ valid this cycle.
- productI  in  PRODUCT_WIDTH  signed in-phase product.
- productQ  in  PRODUCT_WIDTH  signed quadrature product.
- clearErrors  in  1  one-cycle pulse; clears sticky flags.
- tbtValid  out  1  one-cycle strobe; tbtI/tbtQ/turnCount are new.
- tbtI  out  ACC_WIDTH  signed per-turn I sum.
- tbtQ  out  ACC_WIDTH  signed per-turn Q sum.
- turnCount  out  TURN_CNT_WIDTH  completed turns since sync; wraps modulo 2^TURN_CNT_WIDTH.
- synced  out  1  high while in RUN.
- markerMisaligned  out  1  sticky: marker arrived at a non-zero sample index.
- markerOrphan  out  1  sticky: marker arrived without sampleValid.

Behaviour:
- Reset (adcResetN low on an edge):
  - state=IDLE; every output 0; accumulators, sample counter and latched length cleared.
- Effective length: L = clamp(samplesPerTurn, 2, SITE_SAMPLES_PER_TURN).
  - L is latched at each turn start only; mid-turn changes take effect next turn.
- IDLE state:
  - Ignores samples without a marker.
  - On turnMarker & sampleValid: go RUN; acc = product; idx = 1; latch L; synced=1 next cycle.
- RUN state, on each sampleValid:
  - If idx == 0 (turn start): acc = product; latch L.
  - Otherwise: acc = acc + product.
  - idx increments; when idx reaches L-1 on an accepted sample, idx wraps to 0 (flywheel).
  - sampleValid low: hold state, no accumulation.
- Turn completion: the sample accepted at idx == L-1 produces, on the next cycle:
  - tbtValid=1 for exactly one cycle;
  - tbtI/tbtQ = full sum including that sample;
  - turnCount += 1.
  - Latency: 1 cycle after the last sample. Outputs hold until the next completion.
- Marker at idx == 0 with sampleValid: aligned; no action beyond a normal turn start.
- Marker at idx != 0 with sampleValid:
  - Discard the partial sum; no tbtValid for it.
  - Set markerMisaligned.
  - This sample starts a new turn: acc = product, idx = 1.
  - turnCount unchanged.
- Marker at idx == L-1 with sampleValid: treated as misaligned (restart). The completing turn is NOT emitted.
- turnMarker without sampleValid: set markerOrphan; state unchanged.
- Arithmetic: two's-complement, sign-extended to ACC_WIDTH; no saturation needed (width guarantees no overflow at L max).
- clearErrors and a new error event in the same cycle: the event wins; the flag remains 1.
- Reset mid-turn: partial sum discarded; return to IDLE; resync required.

Decomposition:
- Shared package dsbpm_pkg:
  - ACC_WIDTH computation function;
  - state enum {IDLE, RUN};
  - clamp function for L.
- One sub-module, tbt_acc_lane: single-lane signed accumulator with load/add/hold controls. Instantiated twice (I, Q).
- Control FSM, counters and flags live in tbt_accumulator.

Test Plan:
- Aligned operation: samplesPerTurn=4; marker every 4 valid samples; I=+1000, Q=-3 constant.
  - Expect tbtValid every 4 samples, 1 cycle after the last one.
  - tbtI=4000, tbtQ=-12; turnCount 1,2,3; no flags.
- Flywheel: samplesPerTurn=10; one marker, then 50 samples with no marker.
  - Expect 5 tbtValid strobes, each sum 10×sample, turnCount=5.
- Misaligned marker: L=8; marker at idx 5.
  - Expect no emission for the partial turn; markerMisaligned=1.
  - Next tbtValid 8 samples after the marker, containing only the post-marker samples.
- Gaps and extremes: L=100; sampleValid toggling 50%; all products = -2^32.
  - Expect tbtI = -100×2^32 exactly.
  - tbtValid only after the 100th valid sample.
- Clamp and config: samplesPerTurn=0 → turns of 2; =127 → turns of 100.
  - Change from 4 to 6 mid-turn: the current turn completes at 4, the next at 6.
- Reset/orphan/clear:
  - Marker without valid → markerOrphan=1.
  - clearErrors → 0.
  - adcResetN low mid-turn → all outputs 0, synced=0; no tbtValid until the next marker.

Source files
------------

// File: rtl/dsbpm_pkg.sv
// Shared DSBPM datapath definitions: turn-integrator state encoding and
// width/length helpers used by the TbT accumulator and its lanes.
package dsbpm_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  function automatic int acc_width(input int product_width, input int cnt_width);
    return product_width + cnt_width;
  endfunction

  // Effective turn length: at least two samples, at most the site maximum.
  function automatic int clamp_len(input int samples, input int site_max);
    if (samples < 2) return 2;
    if (samples > site_max) return site_max;
    return samples;
  endfunction

endpackage

// File: rtl/tbt_acc_lane.sv
// Single-lane signed accumulator: load restarts the sum with the product,
// add folds the product in, otherwise the running sum holds.
module tbt_acc_lane
  import dsbpm_pkg::*;
#(
  parameter int PRODUCT_WIDTH = 33,
  parameter int ACC_WIDTH     = 40
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic                     add,
  input  logic [PRODUCT_WIDTH-1:0] product,
  output logic [ACC_WIDTH-1:0]     sum
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] product_ext;

  assign product_ext = {{(ACC_WIDTH - PRODUCT_WIDTH){product[PRODUCT_WIDTH-1]}}, product};

  // Sum including the current product; the top captures it on turn completion.
  assign sum = (load ? '0 : acc) + product_ext;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (load || add) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/tbt_accumulator.sv
// Per-channel turn-by-turn I/Q integrator with a flywheel turn counter kept
// aligned to the (possibly sparse) EVR turn marker.
module tbt_accumulator
  import dsbpm_pkg::*;
#(
  parameter int PRODUCT_WIDTH         = 33,
  parameter int SITE_SAMPLES_PER_TURN = 100,
  parameter int CNT_WIDTH             = $clog2(SITE_SAMPLES_PER_TURN + 1),
  parameter int ACC_WIDTH             = acc_width(PRODUCT_WIDTH, CNT_WIDTH),
  parameter int TURN_CNT_WIDTH        = 32
) (
  input  logic                      adcClk,
  input  logic                      adcResetN,
  input  logic [CNT_WIDTH-1:0]      samplesPerTurn,
  input  logic                      turnMarker,
  input  logic                      sampleValid,
  input  logic [PRODUCT_WIDTH-1:0]  productI,
  input  logic [PRODUCT_WIDTH-1:0]  productQ,
  input  logic                      clearErrors,
  output logic                      tbtValid,
  output logic [ACC_WIDTH-1:0]      tbtI,
  output logic [ACC_WIDTH-1:0]      tbtQ,
  output logic [TURN_CNT_WIDTH-1:0] turnCount,
  output logic                      synced,
  output logic                      markerMisaligned,
  output logic                      markerOrphan
);

  state_e               state, state_next;
  logic [CNT_WIDTH-1:0] idx, idx_next;
  logic [CNT_WIDTH-1:0] len_q, len_eff, len_last;
  logic                 lane_load, lane_add;
  logic                 emit, latch_len, sync_evt, misaligned_evt, orphan_evt;
  logic [ACC_WIDTH-1:0] sum_i, sum_q;

  assign len_eff    = CNT_WIDTH'(clamp_len(32'(samplesPerTurn), SITE_SAMPLES_PER_TURN));
  assign len_last   = len_q - CNT_WIDTH'(1);
  assign orphan_evt = turnMarker && !sampleValid;
  assign synced     = (state == RUN);

  always_ff @(posedge adcClk) begin
    if (!adcResetN) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next     = state;
    idx_next       = idx;
    lane_load      = 1'b0;
    lane_add       = 1'b0;
    emit           = 1'b0;
    latch_len      = 1'b0;
    sync_evt       = 1'b0;
    misaligned_evt = 1'b0;
    case (state)
      IDLE: begin
        if (turnMarker && sampleValid) begin
          state_next = RUN;
          lane_load  = 1'b1;
          latch_len  = 1'b1;
          sync_evt   = 1'b1;
          idx_next   = CNT_WIDTH'(1);
        end
      end
      RUN: begin
        if (sampleValid) begin
          // A marker anywhere but idx 0 (including the closing sample)
          // restarts the turn and drops the partial sum unemitted.
          if (turnMarker && idx != '0) begin
            lane_load      = 1'b1;
            latch_len      = 1'b1;
            misaligned_evt = 1'b1;
            idx_next       = CNT_WIDTH'(1);
          end else if (idx == '0) begin
            lane_load = 1'b1;
            latch_len = 1'b1;
            idx_next  = CNT_WIDTH'(1);
          end else begin
            lane_add = 1'b1;
            if (idx == len_last) begin
              emit     = 1'b1;
              idx_next = '0;
            end else begin
              idx_next = idx + CNT_WIDTH'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge adcClk) begin
    if (!adcResetN) begin
      idx              <= '0;
      len_q            <= '0;
      tbtValid         <= 1'b0;
      tbtI             <= '0;
      tbtQ             <= '0;
      turnCount        <= '0;
      markerMisaligned <= 1'b0;
      markerOrphan     <= 1'b0;
    end else begin
      idx      <= idx_next;
      tbtValid <= emit;
      if (latch_len) len_q <= len_eff;
      if (emit) begin
        tbtI      <= sum_i;
        tbtQ      <= sum_q;
        turnCount <= turnCount + TURN_CNT_WIDTH'(1);
      end else if (sync_evt) begin
        turnCount <= '0;
      end
      markerMisaligned <= misaligned_evt || (markerMisaligned && !clearErrors);
      markerOrphan     <= orphan_evt || (markerOrphan && !clearErrors);
    end
  end

  tbt_acc_lane #(
    .PRODUCT_WIDTH(PRODUCT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_lane_i (
    .clk    (adcClk),
    .reset_n(adcResetN),
    .load   (lane_load),
    .add    (lane_add),
    .product(productI),
    .sum    (sum_i)
  );

  tbt_acc_lane #(
    .PRODUCT_WIDTH(PRODUCT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_lane_q (
    .clk    (adcClk),
    .reset_n(adcResetN),
    .load   (lane_load),
    .add    (lane_add),
    .product(productQ),
    .sum    (sum_q)
  );

endmodule

// File: tb/tb_tbt_accumulator.sv
// Scoreboard bench for tbt_accumulator: stimulus queues hand-computed turn
// sums with the clock edge they must follow; a negedge monitor checks them.
module tb_tbt_accumulator;

  logic        adcClk = 1'b0;
  logic        adcResetN;
  logic [6:0]  samplesPerTurn;
  logic        turnMarker;
  logic        sampleValid;
  logic [32:0] productI;
  logic [32:0] productQ;
  logic        clearErrors;
  logic        tbtValid;
  logic [39:0] tbtI;
  logic [39:0] tbtQ;
  logic [31:0] turnCount;
  logic        synced;
  logic        markerMisaligned;
  logic        markerOrphan;

  typedef struct {
    logic [39:0] i;
    logic [39:0] q;
    logic [31:0] cnt;
    int          edge_no;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;

  tbt_accumulator #(
    .PRODUCT_WIDTH        (33),
    .SITE_SAMPLES_PER_TURN(100),
    .TURN_CNT_WIDTH       (32)
  ) dut (
    .adcClk          (adcClk),
    .adcResetN       (adcResetN),
    .samplesPerTurn  (samplesPerTurn),
    .turnMarker      (turnMarker),
    .sampleValid     (sampleValid),
    .productI        (productI),
    .productQ        (productQ),
    .clearErrors     (clearErrors),
    .tbtValid        (tbtValid),
    .tbtI            (tbtI),
    .tbtQ            (tbtQ),
    .turnCount       (turnCount),
    .synced          (synced),
    .markerMisaligned(markerMisaligned),
    .markerOrphan    (markerOrphan)
  );

  always #5 adcClk = ~adcClk;
  always @(posedge adcClk) edges++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp_v, edges);
    end
  endtask

  // Monitor: every strobe must match the oldest queued turn, on the right edge.
  always @(negedge adcClk) begin
    if (tbtValid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tbtValid: got strobe, expected none (edge %0d)", edges);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tbt_latency", 64'(edges), 64'(e.edge_no));
        chk("tbtI", 64'(tbtI), 64'(e.i));
        chk("tbtQ", 64'(tbtQ), 64'(e.q));
        chk("turnCount", 64'(turnCount), 64'(e.cnt));
      end
    end
  end

  task automatic step();
    @(posedge adcClk);
    #1;
  endtask

  task automatic smp(input logic m, input logic [32:0] pi, input logic [32:0] pq);
    turnMarker = m; sampleValid = 1'b1; productI = pi; productQ = pq;
    step();
    turnMarker = 1'b0; sampleValid = 1'b0;
  endtask

  task automatic smp_e(input logic m, input logic [32:0] pi, input logic [32:0] pq,
                       input logic [39:0] ei, input logic [39:0] eq, input logic [31:0] ec);
    exp_t e;
    smp(m, pi, pq);
    e.i = ei; e.q = eq; e.cnt = ec; e.edge_no = edges;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    adcResetN = 1'b0;
    step();
    adcResetN = 1'b1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_tbtValid"}, 64'(tbtValid), 64'd0);
    chk({tag, "_tbtI"}, 64'(tbtI), 64'd0);
    chk({tag, "_tbtQ"}, 64'(tbtQ), 64'd0);
    chk({tag, "_turnCount"}, 64'(turnCount), 64'd0);
    chk({tag, "_synced"}, 64'(synced), 64'd0);
    chk({tag, "_misaligned"}, 64'(markerMisaligned), 64'd0);
    chk({tag, "_orphan"}, 64'(markerOrphan), 64'd0);
  endtask

  initial begin
    adcResetN = 1'b0; samplesPerTurn = 7'd4; turnMarker = 1'b0; sampleValid = 1'b0;
    productI = '0; productQ = '0; clearErrors = 1'b0;
    step(); step();
    adcResetN = 1'b1;
    chk_idle_outputs("reset");

    // Aligned: L=4, marker every 4 samples, I=+1000, Q=-3.
    for (int t = 1; t <= 3; t++) begin
      smp(1'b1, 33'sd1000, -33'sd3);
      smp(1'b0, 33'sd1000, -33'sd3);
      smp(1'b0, 33'sd1000, -33'sd3);
      smp_e(1'b0, 33'sd1000, -33'sd3, 40'sd4000, -40'sd12, 32'(t));
    end
    step();
    chk("aligned_synced", 64'(synced), 64'd1);
    chk("aligned_misaligned", 64'(markerMisaligned), 64'd0);
    chk("aligned_orphan", 64'(markerOrphan), 64'd0);

    // Flywheel: L=10, single marker, 50 samples.
    do_reset();
    samplesPerTurn = 7'd10;
    for (int n = 0; n < 50; n++) begin
      if (n % 10 == 9) smp_e(1'b0, 33'sd7, -33'sd5, 40'sd70, -40'sd50, 32'((n + 1) / 10));
      else             smp(n == 0, 33'sd7, -33'sd5);
    end
    step();
    chk("flywheel_turnCount", 64'(turnCount), 64'd5);

    // Misaligned marker at idx 5 with L=8, then a marker on the closing sample.
    do_reset();
    samplesPerTurn = 7'd8;
    for (int n = 0; n < 5; n++) smp(n == 0, 33'sd1, 33'sd1);
    smp(1'b1, 33'sd2, 33'sd3);
    for (int n = 0; n < 6; n++) smp(1'b0, 33'sd2, 33'sd3);
    smp_e(1'b0, 33'sd2, 33'sd3, 40'sd16, 40'sd24, 32'd1);
    chk("misaligned_flag", 64'(markerMisaligned), 64'd1);
    for (int n = 0; n < 7; n++) smp(1'b0, 33'sd9, 33'sd9);
    smp(1'b1, 33'sd5, -33'sd1);
    for (int n = 0; n < 6; n++) smp(1'b0, 33'sd5, -33'sd1);
    smp_e(1'b0, 33'sd5, -33'sd1, 40'sd40, -40'sd8, 32'd2);

    // Extremes with 50% valid: L=100, I=-2^32, Q=2^32-1.
    do_reset();
    samplesPerTurn = 7'd100;
    for (int n = 0; n < 100; n++) begin
      if (n == 99) smp_e(1'b0, 33'h1_0000_0000, 33'h0_FFFF_FFFF,
                         -40'sd429496729600, 40'sd429496729500, 32'd1);
      else         smp(n == 0, 33'h1_0000_0000, 33'h0_FFFF_FFFF);
      step();
    end

    // Clamp low (0 -> 2), clamp high (127 -> 100), then 4 -> 6 mid-turn.
    do_reset();
    samplesPerTurn = 7'd0;
    smp(1'b1, 33'sd3, 33'sd1);
    smp_e(1'b0, 33'sd3, 33'sd1, 40'sd6, 40'sd2, 32'd1);
    smp(1'b0, 33'sd3, 33'sd1);
    smp_e(1'b0, 33'sd3, 33'sd1, 40'sd6, 40'sd2, 32'd2);
    samplesPerTurn = 7'd127;
    for (int n = 0; n < 99; n++) smp(1'b0, 33'sd1, -33'sd1);
    smp_e(1'b0, 33'sd1, -33'sd1, 40'sd100, -40'sd100, 32'd3);
    samplesPerTurn = 7'd4;
    smp(1'b0, 33'sd2, -33'sd2);
    smp(1'b0, 33'sd2, -33'sd2);
    samplesPerTurn = 7'd6;
    smp(1'b0, 33'sd2, -33'sd2);
    smp_e(1'b0, 33'sd2, -33'sd2, 40'sd8, -40'sd8, 32'd4);
    for (int n = 0; n < 5; n++) smp(1'b0, 33'sd2, -33'sd2);
    smp_e(1'b0, 33'sd2, -33'sd2, 40'sd12, -40'sd12, 32'd5);

    // Orphan marker mid-turn leaves the turn intact; clear and clear-vs-event.
    do_reset();
    samplesPerTurn = 7'd4;
    smp(1'b1, 33'sd1, 33'sd1);
    smp(1'b0, 33'sd1, 33'sd1);
    turnMarker = 1'b1;
    step();
    turnMarker = 1'b0;
    chk("orphan_flag", 64'(markerOrphan), 64'd1);
    chk("orphan_synced", 64'(synced), 64'd1);
    chk("orphan_no_misaligned", 64'(markerMisaligned), 64'd0);
    smp(1'b0, 33'sd1, 33'sd1);
    smp_e(1'b0, 33'sd1, 33'sd1, 40'sd4, 40'sd4, 32'd1);
    clearErrors = 1'b1;
    step();
    clearErrors = 1'b0;
    chk("orphan_cleared", 64'(markerOrphan), 64'd0);
    clearErrors = 1'b1; turnMarker = 1'b1;
    step();
    clearErrors = 1'b0; turnMarker = 1'b0;
    chk("clear_vs_event", 64'(markerOrphan), 64'd1);
    clearErrors = 1'b1;
    step();
    clearErrors = 1'b0;

    // Reset mid-turn, unmarked samples ignored, then resync.
    smp(1'b1, 33'sd5, 33'sd5);
    smp(1'b0, 33'sd5, 33'sd5);
    do_reset();
    chk_idle_outputs("midreset");
    for (int n = 0; n < 5; n++) smp(1'b0, 33'sd9, 33'sd9);
    chk("unsynced_after_reset", 64'(synced), 64'd0);
    smp(1'b1, 33'sd1, -33'sd2);
    chk("resynced", 64'(synced), 64'd1);
    smp(1'b0, 33'sd1, -33'sd2);
    smp(1'b0, 33'sd1, -33'sd2);
    smp_e(1'b0, 33'sd1, -33'sd2, 40'sd4, -40'sd8, 32'd1);

    repeat (4) step();
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_tbtValid: got none, expected I=%0d at edge %0d", $signed(e.i), e.edge_no);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
